// File: rtl/block_collision_scanner.sv
// Per-frame scanner: tests one block per clock against a snapshot of the player box,
// then pulses col/done for one cycle and updates the held contact report.
module block_collision_scanner #(
  parameter int NUM_BLOCKS = 8,
  parameter int IDX_W      = 3,
  parameter int PLAYER_W   = 16,
  parameter int PLAYER_H   = 16,
  parameter int BLOCK_SIZE = 16
) (
  input  logic                      sim_clk,
  input  logic                      reset,
  input  logic                      frame_tick,
  input  logic [9:0]                player_x,
  input  logic [9:0]                player_y,
  input  logic                      player_attack,
  input  logic [21*NUM_BLOCKS-1:0]  block_states,
  output logic [NUM_BLOCKS-1:0]     col,
  output logic                      done,
  output logic                      busy,
  output logic                      hit_any,
  output logic [IDX_W-1:0]          hit_index
);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t                 state, stateNxt;
  logic [IDX_W-1:0]       idx;
  logic [NUM_BLOCKS-1:0]  hitVec, scanVec, colNxt;
  logic                   doneNxt;
  logic [9:0]             pxLat, pyLat;
  logic                   atkLat;
  logic [20:0]            blk [NUM_BLOCKS];
  logic [20:0]            curBlk;
  logic [10:0]            bx, by, px, py;
  logic                   hitNow, lastIdx;
  logic [IDX_W-1:0]       lowIdx;

  for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_unpack
    assign blk[i] = block_states[21*i +: 21];
  end

  // Everything widened to 11 bits so box edges near 1023 never wrap.
  assign curBlk = blk[idx];
  assign bx     = {1'b0, curBlk[20:11]};
  assign by     = {1'b0, curBlk[10:1]};
  assign px     = {1'b0, pxLat};
  assign py     = {1'b0, pyLat};
  assign hitNow = curBlk[0]
                && (px < bx + 11'(BLOCK_SIZE)) && (bx < px + 11'(PLAYER_W))
                && (py < by + 11'(BLOCK_SIZE)) && (by < py + 11'(PLAYER_H));
  assign lastIdx = (idx == IDX_W'(NUM_BLOCKS-1));

  always_comb begin
    scanVec      = hitVec;
    scanVec[idx] = hitNow;
  end

  always_comb begin
    lowIdx = '0;
    for (int i = NUM_BLOCKS-1; i >= 0; i--)
      if (hitVec[i]) lowIdx = IDX_W'(i);
  end

  always_ff @(posedge sim_clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (frame_tick) stateNxt = SCAN;
      SCAN:    if (lastIdx)    stateNxt = REPORT;
      REPORT:                  stateNxt = IDLE;
      default:                 stateNxt = IDLE;
    endcase
  end

  // col/done are registered, so they are loaded on the edge that enters REPORT
  // using the scan vector that already includes the final block.
  always_comb begin
    colNxt  = '0;
    doneNxt = 1'b0;
    if (state == SCAN && lastIdx) begin
      doneNxt = 1'b1;
      colNxt  = atkLat ? scanVec : '0;
    end
  end

  always_ff @(posedge sim_clk) begin
    if (reset) begin
      idx       <= '0;
      hitVec    <= '0;
      pxLat     <= '0;
      pyLat     <= '0;
      atkLat    <= 1'b0;
      col       <= '0;
      done      <= 1'b0;
      hit_any   <= 1'b0;
      hit_index <= '0;
    end else begin
      col  <= colNxt;
      done <= doneNxt;
      case (state)
        IDLE: if (frame_tick) begin
          pxLat  <= player_x;
          pyLat  <= player_y;
          atkLat <= player_attack;
          hitVec <= '0;
          idx    <= '0;
        end
        SCAN: begin
          hitVec <= scanVec;
          if (!lastIdx) idx <= idx + 1'b1;
        end
        REPORT: begin
          hit_any   <= |hitVec;
          hit_index <= lowIdx;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_block_collision_scanner.sv
// Table-driven bench with an expected-result queue popped on each done pulse.
module tb_block_collision_scanner;
  localparam int NB = 8;

  logic            sim_clk = 0;
  logic            reset, frame_tick, player_attack;
  logic [9:0]      player_x, player_y;
  logic [21*NB-1:0] block_states;
  logic [NB-1:0]   col;
  logic            done, busy, hit_any;
  logic [2:0]      hit_index;

  block_collision_scanner #(.NUM_BLOCKS(NB), .IDX_W(3)) dut (
    .sim_clk(sim_clk), .reset(reset), .frame_tick(frame_tick),
    .player_x(player_x), .player_y(player_y), .player_attack(player_attack),
    .block_states(block_states), .col(col), .done(done), .busy(busy),
    .hit_any(hit_any), .hit_index(hit_index)
  );

  always #5 sim_clk = ~sim_clk;

  typedef struct packed {
    logic [9:0]       px, py;
    logic             atk;
    logic [21*NB-1:0] bs;
    logic [NB-1:0]    col;
    logic             any;
    logic [2:0]       idx;
  } vec_t;

  vec_t tbl [12];
  vec_t sb [$];
  int   nVec = 0, nMis = 0;

  function automatic logic [21*NB-1:0] put(input logic [21*NB-1:0] v, input int i,
                                           input logic [9:0] x, input logic [9:0] y, input logic vis);
    v[21*i +: 21] = {x, y, vis};
    return v;
  endfunction

  function automatic vec_t mk(input logic [9:0] px, input logic [9:0] py, input logic atk,
                              input logic [21*NB-1:0] bs, input logic [NB-1:0] c,
                              input logic any, input logic [2:0] idx);
    vec_t v;
    v.px = px; v.py = py; v.atk = atk; v.bs = bs; v.col = c; v.any = any; v.idx = idx;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One frame starting in the current cycle T; runs through cycle T+10.
  task automatic doFrame(input vec_t v, input int reTickAt, input int rstAt,
                         output logic [NB-1:0] gotCol);
    vec_t rec;
    bit   have;
    logic expDone, expBusy;
    have = 0; gotCol = '0; rec = '0;
    player_x = v.px; player_y = v.py; player_attack = v.atk;
    block_states = v.bs; frame_tick = 1;
    if (rstAt == 0) sb.push_back(v);
    for (int c = 1; c <= 10; c++) begin
      @(posedge sim_clk); #1;
      frame_tick = (c == reTickAt);
      reset      = (c == rstAt);
      player_x = 10'($urandom); player_y = 10'($urandom); player_attack = 1'($urandom);
      expDone = (rstAt == 0 && c == 9);
      expBusy = (rstAt != 0) ? (c <= rstAt) : (c <= 9);
      chk("done", 32'(done), 32'(expDone));
      chk("busy", 32'(busy), 32'(expBusy));
      if (done) begin
        if (sb.size() == 0) begin
          nVec++; nMis++;
          $display("FAIL sb_empty: done with no expected entry at %0t", $time);
        end else begin
          rec = sb.pop_front(); have = 1;
          gotCol = col;
          chk("col", 32'(col), 32'(rec.col));
        end
      end else begin
        chk("col_quiet", 32'(col), 32'(0));
        if (expDone && sb.size() > 0) begin rec = sb.pop_front(); have = 1; end
      end
      if (c == 10 && have) begin
        chk("hit_any", 32'(hit_any), 32'(rec.any));
        chk("hit_index", 32'(hit_index), 32'(rec.idx));
      end
      if (rstAt != 0 && c > rstAt) begin
        chk("rst_hit_any", 32'(hit_any), 32'(0));
        chk("rst_hit_index", 32'(hit_index), 32'(0));
      end
    end
    reset = 0;
  endtask

  initial begin
    logic [21*NB-1:0] z, b;
    logic [NB-1:0]    gc;
    z = '0;
    tbl[0]  = mk(100, 100, 1, put(z, 3, 110, 105, 1), 8'h08, 1, 3);
    tbl[1]  = mk(100, 100, 0, put(z, 3, 110, 105, 1), 8'h00, 1, 3);
    tbl[2]  = mk(100, 100, 1, put(z, 0, 116, 100, 1), 8'h00, 0, 0);
    tbl[3]  = mk(100, 100, 1, put(z, 6, 115, 100, 1), 8'h40, 1, 6);
    tbl[4]  = mk(100, 100, 1, put(put(z, 2, 90, 90, 1), 5, 108, 92, 1), 8'h24, 1, 2);
    tbl[5]  = mk(1010, 1010, 1, put(z, 1, 1015, 1015, 1), 8'h02, 1, 1);
    tbl[6]  = mk(1010, 1010, 1, put(z, 1, 0, 0, 1), 8'h00, 0, 0);
    tbl[7]  = mk(100, 100, 1, put(z, 4, 100, 100, 0), 8'h00, 0, 0);
    b = z;
    for (int i = 0; i < NB; i++) b = put(b, i, 100, 100, 1);
    tbl[8]  = mk(100, 100, 1, b, 8'hff, 1, 0);
    tbl[9]  = mk(100, 100, 1, put(z, 7, 100, 84, 1), 8'h00, 0, 0);
    tbl[10] = mk(100, 100, 1, put(z, 7, 100, 85, 1), 8'h80, 1, 7);
    tbl[11] = mk(100, 100, 0, put(put(z, 7, 100, 85, 1), 4, 99, 115, 1), 8'h00, 1, 4);

    reset = 1; frame_tick = 0; player_x = 0; player_y = 0; player_attack = 0; block_states = '0;
    repeat (3) @(posedge sim_clk);
    #1;
    chk("rst_col", 32'(col), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_hit_any", 32'(hit_any), 32'(0));
    chk("rst_hit_index", 32'(hit_index), 32'(0));
    reset = 0;

    // Back-to-back frames: each new tick lands in cycle T+10.
    for (int i = 0; i < 12; i++) doFrame(tbl[i], 0, 0, gc);

    // Tick re-asserted mid-scan must not start a second frame.
    doFrame(tbl[0], 3, 0, gc);

    // Reset mid-scan after a frame that left hit_any set.
    doFrame(tbl[8], 0, 0, gc);
    doFrame(tbl[0], 0, 4, gc);

    // Emulate destroyable blocks: pulsed blocks read {0,0,0} on the rescan.
    doFrame(tbl[4], 0, 0, gc);
    b = tbl[4].bs;
    for (int i = 0; i < NB; i++) if (gc[i]) b = put(b, i, 0, 0, 0);
    doFrame(mk(100, 100, 1, b, 8'h00, 0, 0), 0, 0, gc);

    repeat (3) @(posedge sim_clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule
